// File: rtl/register_fifo_r_en_pkg.sv
// Shared definitions for the register-based FIFO and its word registers.
//   WIDTH_DEF : default data word width
//   DEPTH_DEF : default number of storage words
//   clog2()   : pointer width derivation used for AW
package register_fifo_r_en_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/register_fifo_r_en_word.sv
// register_w_r_en: one enable-gated storage word of the FIFO.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears the word to 0
//   en      : load d_in on the next rising edge
//   d_in    : data to load
//   d_out   : stored word
module register_w_r_en
    import register_fifo_r_en_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_out <= '0;
        end else if (en) begin
            d_out <= d_in;
        end
    end

endmodule

// File: rtl/register_fifo_r_en.sv
// register_fifo_r_en: show-ahead FIFO built from DEPTH word registers.
//   clk, reset_n     : clock and asynchronous active-low reset
//   clr              : synchronous clear of pointers, count and error flags
//   wr_en, d_in      : push request and data
//   rd_en            : pop request
//   d_out            : head word, valid while empty is low
//   full, empty      : decoded from the registered count
//   count            : stored words, 0..DEPTH
//   wr_err, rd_err   : one-cycle pulses after a rejected push / pop
module register_fifo_r_en
    import register_fifo_r_en_pkg::*;
#(
    parameter int  WIDTH = WIDTH_DEF,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] d_out,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             wr_err,
    output logic             rd_err
);

    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;
    logic [WIDTH-1:0] words [DEPTH];

    // clr wins over both requests, so it also blocks the storage write.
    // A push into a full FIFO is still taken when a pop frees a slot the same edge.
    assign pop_ok  = rd_en & ~clr & (count != '0);
    assign push_ok = wr_en & ~clr & ((count != CNT_FULL) | pop_ok);

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam logic [AW-1:0] IDX = AW'(i);
        register_w_r_en #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (push_ok && (wr_ptr == IDX)),
            .d_in    (d_in),
            .d_out   (words[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            wr_err <= wr_en & ~push_ok;
            rd_err <= rd_en & ~pop_ok;
        end
    end

    assign d_out = words[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule
